pool_out_drain: RTL and testbench
=================================

Name: pool_out_drain

Overview:
- Drains the pooled output tile to the output SRAM after a layer finishes.
- Sits directly downstream of the pool/readout array. It sequences that array's registered read port row by row, one OUTPUT_SRAM_LEN-wide chunk at a time.
- Writes each chunk as one word to the output SRAM write port, honouring a ready handshake.
- Reports busy/done to the layer controller.

Parameters:
- OUTPUT_HEIGHT, `OUTPUT_HEIGHT: rows in the output tile.
- OUTPUT_WIDTH, `OUTPUT_WIDTH: columns in the output tile.
- OUTPUT_SRAM_LEN, `OUTPUT_SRAM_LEN: elements per SRAM word. Must divide OUTPUT_WIDTH.
- BIN_LEN, `BIN_LEN: bits per element.
- ADDR_W, 16: output SRAM word-address width.
- Derived: CHUNKS = OUTPUT_WIDTH/OUTPUT_SRAM_LEN; WORDS = OUTPUT_HEIGHT*CHUNKS.

Ports:
- clock  in  1  clock; all logic is posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begin a drain. Accepted only in IDLE.
- base_addr  in  ADDR_W  SRAM word address of tile element (0,0). Latched on accepted start.
- pool_r_en  out  1  read enable to the pool array.
- pool_r  out  clog2(OUTPUT_HEIGHT)  row index.
- pool_c  out  clog2(OUTPUT_WIDTH)  first column of the chunk.
- pool_data  in  BIN_LEN*OUTPUT_SRAM_LEN  chunk from the pool array. Valid in the cycle after pool_r_en; may be Z otherwise.
- sram_wr_en  out  1  write request.
- sram_wr_addr  out  ADDR_W  write word address.
- sram_wr_data  out  BIN_LEN*OUTPUT_SRAM_LEN  write data.
- sram_wr_ready  in  1  a write completes in a cycle where sram_wr_en && sram_wr_ready.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset: state=IDLE; all outputs 0, including pool_r, pool_c, sram_wr_addr and sram_wr_data. Internal row, chunk and address counters are cleared.
- Reset mid-drain: abort immediately, no further writes, no done pulse.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - On start, latch base_addr into addr_q and clear row and chunk.
  - Go to READ.
  - start in any other state is ignored; it is not queued.
- READ (1 cycle):
  - pool_r_en=1, pool_r=row, pool_c=chunk*OUTPUT_SRAM_LEN.
  - Go to WAIT.
- WAIT (1 cycle):
  - pool_r_en=0.
  - Register pool_data into sram_wr_data at the end of the cycle. This is the only cycle in which pool_data is sampled; Z outside it is never captured.
  - Go to WRITE.
- WRITE:
  - sram_wr_en=1; sram_wr_addr=addr_q; sram_wr_data held stable.
  - If sram_wr_ready=0: stay in WRITE, holding en, addr and data unchanged with no re-read.
  - If sram_wr_ready=1: addr_q++. Then:
    - If chunk==CHUNKS-1, set chunk=0 and row++; otherwise chunk++.
    - If the accepted word was the last (row==OUTPUT_HEIGHT-1 and chunk==CHUNKS-1), go to DONE; otherwise go to READ.
- DONE (1 cycle): done=1, then go to IDLE. A start in this cycle is ignored.
- Address rule: addr = base_addr + row*CHUNKS + chunk, realised as an incrementer.
  - The incrementer wraps modulo 2^ADDR_W.
  - Wrap is not flagged.
- Output timing: sram_wr_en, pool_r_en and done are registered outputs decoded from state; no combinational path from inputs to outputs.
- Latency with sram_wr_ready held at 1:
  - 3 cycles per word.
  - start sampled in cycle 0 → first READ in cycle 1 → first write in cycle 3 → last write in cycle 3*WORDS → done in cycle 3*WORDS+1.
  - busy is high in cycles 1..3*WORDS+1.
- Each ready=0 cycle in WRITE adds exactly one cycle.

Decomposition:
- Shared package / sys_defs.svh:
  - drain_state_t enum (IDLE, READ, WAIT, WRITE, DONE).
  - CHUNKS and WORDS derivations.
  - A compile-time check that OUTPUT_WIDTH % OUTPUT_SRAM_LEN == 0.
- One sub-module, drain_addr_gen. It holds the row, chunk and addr_q counters and provides an advance input, a load input and an is_last output.
- The FSM stays in pool_out_drain.

Test Plan (OUTPUT_HEIGHT=4, OUTPUT_WIDTH=8, OUTPUT_SRAM_LEN=4, BIN_LEN=8):
- Basic drain:
  - Stimulus: base_addr=0x100, ready=1, pool model returns chunk = {r,c} pattern, start at cycle 0.
  - Response: 8 writes to 0x100..0x107 in cycles 3,6,...,24, with data matching (r,c) = (0,0),(0,4),(1,0),...,(3,4). done pulses at cycle 25 only; busy is high in cycles 1..25.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles during the 3rd write.
  - Response: addr 0x102 and its data are held stable, no extra pool_r_en, and done moves to cycle 30.
- Start while busy:
  - Stimulus: pulse start at cycle 10, and again in the DONE cycle.
  - Response: both are ignored; exactly 8 writes and one done.
- Reset mid-drain:
  - Stimulus: reset at cycle 12.
  - Response: next cycle all outputs 0, state IDLE, no done. A new start with base_addr=0 then yields writes at 0..7.
- Z tolerance:
  - Stimulus: pool_data driven Z except in the cycle after pool_r_en.
  - Response: sram_wr_data is never X/Z while sram_wr_en=1.
- Address wrap:
  - Stimulus: base_addr=0xFFFE.
  - Response: write addresses are 0xFFFE, 0xFFFF, 0x0000..0x0005.

Source files
------------

// File: rtl/pool_out_drain_pkg.sv
// Shared types and tile geometry for the pooled-output drain.
package pool_out_drain_pkg;

   localparam int unsigned OUTPUT_HEIGHT   = 4;
   localparam int unsigned OUTPUT_WIDTH    = 8;
   localparam int unsigned OUTPUT_SRAM_LEN = 4;
   localparam int unsigned BIN_LEN         = 8;
   localparam int unsigned ADDR_W          = 16;

   localparam int unsigned CHUNKS = OUTPUT_WIDTH / OUTPUT_SRAM_LEN;
   localparam int unsigned WORDS  = OUTPUT_HEIGHT * CHUNKS;
   localparam int unsigned DATA_W = BIN_LEN * OUTPUT_SRAM_LEN;

   localparam bit WIDTH_DIVIDES = (OUTPUT_WIDTH % OUTPUT_SRAM_LEN) == 0;

   // Index widths never collapse to zero, even for a single row/column/chunk.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   localparam int unsigned ROW_W   = clog2_min1(OUTPUT_HEIGHT);
   localparam int unsigned COL_W   = clog2_min1(OUTPUT_WIDTH);
   localparam int unsigned CHUNK_W = clog2_min1(CHUNKS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } drain_state_t;

endpackage

// File: rtl/drain_addr_gen.sv
// Row/chunk position and SRAM word address for the drain; address is a wrapping incrementer.
module drain_addr_gen
   import pool_out_drain_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                i_load,
   input  logic                i_advance,
   input  logic [ADDR_W-1:0]   i_base_addr,
   output logic [ROW_W-1:0]    o_row,
   output logic [CHUNK_W-1:0]  o_chunk,
   output logic [ADDR_W-1:0]   o_addr,
   output logic                o_is_last_c
);

   logic [ROW_W-1:0]   r_row;
   logic [CHUNK_W-1:0] r_chunk;
   logic [ADDR_W-1:0]  r_addr;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_row   <= '0;
         r_chunk <= '0;
         r_addr  <= '0;
      end else if (i_load) begin
         r_row   <= '0;
         r_chunk <= '0;
         r_addr  <= i_base_addr;
      end else if (i_advance) begin
         r_addr <= r_addr + ADDR_W'(1);
         if (r_chunk == CHUNK_W'(CHUNKS - 1)) begin
            r_chunk <= '0;
            r_row   <= r_row + ROW_W'(1);
         end else begin
            r_chunk <= r_chunk + CHUNK_W'(1);
         end
      end
   end

   assign o_row       = r_row;
   assign o_chunk     = r_chunk;
   assign o_addr      = r_addr;
   assign o_is_last_c = (r_row == ROW_W'(OUTPUT_HEIGHT - 1)) &&
                        (r_chunk == CHUNK_W'(CHUNKS - 1));

endmodule

// File: rtl/pool_out_drain.sv
// Drains the pooled output tile into the output SRAM, one chunk-wide word per READ/WAIT/WRITE pass.
module pool_out_drain
   import pool_out_drain_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                i_start,
   input  logic [ADDR_W-1:0]   i_base_addr,
   output logic                o_pool_r_en,
   output logic [ROW_W-1:0]    o_pool_r,
   output logic [COL_W-1:0]    o_pool_c,
   input  logic [DATA_W-1:0]   i_pool_data,
   output logic                o_sram_wr_en,
   output logic [ADDR_W-1:0]   o_sram_wr_addr,
   output logic [DATA_W-1:0]   o_sram_wr_data,
   input  logic                i_sram_wr_ready,
   output logic                o_busy,
   output logic                o_done
);

   if (!WIDTH_DIVIDES || (WORDS == 0)) begin : g_bad_geometry
      $error("pool_out_drain: OUTPUT_WIDTH must be a nonzero multiple of OUTPUT_SRAM_LEN");
   end

   drain_state_t        r_state;
   logic                r_pool_r_en;
   logic                r_sram_wr_en;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_wr_data;

   logic                w_load;
   logic                w_advance;
   logic                w_is_last;
   logic [ROW_W-1:0]    w_row;
   logic [CHUNK_W-1:0]  w_chunk;
   logic [ADDR_W-1:0]   w_addr;

   assign w_load    = (r_state == IDLE) && i_start;
   assign w_advance = (r_state == WRITE) && i_sram_wr_ready;

   drain_addr_gen u_addr_gen (
      .clock       (clock),
      .reset       (reset),
      .i_load      (w_load),
      .i_advance   (w_advance),
      .i_base_addr (i_base_addr),
      .o_row       (w_row),
      .o_chunk     (w_chunk),
      .o_addr      (w_addr),
      .o_is_last_c (w_is_last)
   );

   // Control outputs are set on entry to the state that owns them, so they are flop outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_pool_r_en  <= 1'b0;
         r_sram_wr_en <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_wr_data    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state     <= READ;
                  r_pool_r_en <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            READ: begin
               r_state     <= WAIT;
               r_pool_r_en <= 1'b0;
            end
            WAIT: begin
               r_state      <= WRITE;
               r_sram_wr_en <= 1'b1;
               r_wr_data    <= i_pool_data;
            end
            WRITE: begin
               if (i_sram_wr_ready) begin
                  r_sram_wr_en <= 1'b0;
                  if (w_is_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= READ;
                     r_pool_r_en <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state      <= IDLE;
               r_pool_r_en  <= 1'b0;
               r_sram_wr_en <= 1'b0;
               r_busy       <= 1'b0;
               r_done       <= 1'b0;
            end
         endcase
      end
   end

   assign o_pool_r_en    = r_pool_r_en;
   assign o_pool_r       = w_row;
   assign o_pool_c       = COL_W'(w_chunk) * COL_W'(OUTPUT_SRAM_LEN);
   assign o_sram_wr_en   = r_sram_wr_en;
   assign o_sram_wr_addr = w_addr;
   assign o_sram_wr_data = r_wr_data;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

endmodule

// File: tb/tb_pool_out_drain.sv
// Directed bench for pool_out_drain: cycle-accurate write/done timing, backpressure, reset abort, wrap.
module tb_pool_out_drain;
   import pool_out_drain_pkg::*;

   logic                clock = 1'b0;
   logic                reset;
   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic                pool_r_en;
   logic [ROW_W-1:0]    pool_r;
   logic [COL_W-1:0]    pool_c;
   logic [DATA_W-1:0]   pool_data;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                ready;
   logic                busy;
   logic                done;

   pool_out_drain dut (
      .clock           (clock),
      .reset           (reset),
      .i_start         (start),
      .i_base_addr     (base_addr),
      .o_pool_r_en     (pool_r_en),
      .o_pool_r        (pool_r),
      .o_pool_c        (pool_c),
      .i_pool_data     (pool_data),
      .o_sram_wr_en    (wr_en),
      .o_sram_wr_addr  (wr_addr),
      .o_sram_wr_data  (wr_data),
      .i_sram_wr_ready (ready),
      .o_busy          (busy),
      .o_done          (done)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Hand-computed words in drain order: element j of (r,c) is 8'h{r}{c+j}.
   logic [31:0] exp_data [8] = '{32'h03020100, 32'h07060504, 32'h13121110, 32'h17161514,
                                 32'h23222120, 32'h27262524, 32'h33323130, 32'h37363534};

   function automatic logic [DATA_W-1:0] chunk_pat(input int r, input int c);
      logic [DATA_W-1:0] d;
      for (int j = 0; j < int'(OUTPUT_SRAM_LEN); j++)
         d[j*BIN_LEN +: BIN_LEN] = BIN_LEN'(r * 16 + c + j);
      return d;
   endfunction

   // Registered pool read port: data only in the cycle after pool_r_en, Z otherwise.
   always @(posedge clock) begin
      if (pool_r_en) pool_data <= chunk_pat(int'(pool_r), int'(pool_c));
      else           pool_data <= 'z;
   end

   int edge_cnt = 0;
   int t_start  = 0;
   bit mon_on   = 1'b0;
   always @(posedge clock) edge_cnt++;

   int          wq_cyc  [$];
   logic [15:0] wq_addr [$];
   logic [31:0] wq_data [$];
   int n_ren, n_done, done_cyc, busy_cnt, busy_first, busy_last;
   int xz_bad, stall_cnt, stall_bad;
   bit          prev_stall;
   logic [15:0] prev_addr;
   logic [31:0] prev_data;

   // Mid-cycle observer; cycle 1 is the first cycle after start is sampled.
   always @(negedge clock) begin
      int cyc;
      #1;
      if (mon_on) begin
         cyc = edge_cnt - t_start + 1;
         if (pool_r_en) n_ren++;
         if (done) begin
            if (n_done == 0) done_cyc = cyc;
            n_done++;
         end
         if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
         end
         if (wr_en && $isunknown(wr_data)) xz_bad++;
         if (wr_en && prev_stall && (wr_addr !== prev_addr || wr_data !== prev_data)) stall_bad++;
         if (wr_en && !ready) begin
            stall_cnt++;
            prev_stall = 1'b1;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
         end else begin
            prev_stall = 1'b0;
         end
         if (wr_en && ready) begin
            wq_cyc.push_back(cyc);
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
         end
      end
   end

   task automatic check_outputs_zero(input string pfx);
      check_val({pfx, "_busy"},    64'(busy),      64'(0));
      check_val({pfx, "_done"},    64'(done),      64'(0));
      check_val({pfx, "_wr_en"},   64'(wr_en),     64'(0));
      check_val({pfx, "_r_en"},    64'(pool_r_en), 64'(0));
      check_val({pfx, "_addr"},    64'(wr_addr),   64'(0));
      check_val({pfx, "_data"},    64'(wr_data),   64'(0));
      check_val({pfx, "_pool_rc"}, 64'({pool_r, pool_c}), 64'(0));
   endtask

   // One drain with optional backpressure (cycles 9..13), ignored starts (10, 25) or reset at 12.
   task automatic run_drain(input logic [15:0] base, input bit bp, input bit inj,
                            input bit rst12, input int n_cyc);
      wq_cyc.delete(); wq_addr.delete(); wq_data.delete();
      n_ren = 0; n_done = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
      xz_bad = 0; stall_cnt = 0; stall_bad = 0; prev_stall = 1'b0;
      @(negedge clock);
      base_addr = base; start = 1'b1; ready = 1'b1; reset = 1'b0;
      @(posedge clock);
      #1 t_start = edge_cnt;
      mon_on = 1'b1;
      for (int c = 1; c <= n_cyc; c++) begin
         @(negedge clock);
         start = inj && (c == 10 || c == 25);
         ready = !(bp && c >= 9 && c <= 13);
         reset = rst12 && (c == 12);
         if (rst12 && c == 13) begin
            #2 check_outputs_zero("rst_mid");
         end
      end
      mon_on = 1'b0;
      start = 1'b0; ready = 1'b1; reset = 1'b0;
   endtask

   task automatic check_writes(input string pfx, input logic [15:0] base, input int stall);
      check_val({pfx, "_nwr"}, 64'(wq_cyc.size()), 64'(8));
      for (int k = 0; k < 8 && k < wq_cyc.size(); k++) begin
         check_val($sformatf("%s_addr%0d", pfx, k), 64'(wq_addr[k]), 64'(16'(base + 16'(k))));
         check_val($sformatf("%s_data%0d", pfx, k), 64'(wq_data[k]), 64'(exp_data[k]));
         check_val($sformatf("%s_cyc%0d", pfx, k),  64'(wq_cyc[k]),
                   64'(3 + 3 * k + ((k >= 2) ? stall : 0)));
      end
      check_val({pfx, "_xz"}, 64'(xz_bad), 64'(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ready = 1'b1; base_addr = '0;
      repeat (3) @(negedge clock);
      #2 check_outputs_zero("reset");
      @(negedge clock) reset = 1'b0;

      run_drain(16'h0100, 1'b0, 1'b0, 1'b0, 30);
      check_writes("basic", 16'h0100, 0);
      check_val("basic_ndone",     64'(n_done),     64'(1));
      check_val("basic_done_cyc",  64'(done_cyc),   64'(25));
      check_val("basic_busy_lo",   64'(busy_first), 64'(1));
      check_val("basic_busy_hi",   64'(busy_last),  64'(25));
      check_val("basic_busy_cnt",  64'(busy_cnt),   64'(25));
      check_val("basic_nren",      64'(n_ren),      64'(8));

      run_drain(16'h0100, 1'b1, 1'b0, 1'b0, 36);
      check_writes("bp", 16'h0100, 5);
      check_val("bp_done_cyc",  64'(done_cyc),  64'(30));
      check_val("bp_ndone",     64'(n_done),    64'(1));
      check_val("bp_nren",      64'(n_ren),     64'(8));
      check_val("bp_stall_cnt", 64'(stall_cnt), 64'(5));
      check_val("bp_stall_hold",64'(stall_bad), 64'(0));

      run_drain(16'h0200, 1'b0, 1'b1, 1'b0, 35);
      check_writes("busy_start", 16'h0200, 0);
      check_val("busy_start_ndone", 64'(n_done),   64'(1));
      check_val("busy_start_dcyc",  64'(done_cyc), 64'(25));
      check_val("busy_start_nren",  64'(n_ren),    64'(8));

      run_drain(16'h0300, 1'b0, 1'b0, 1'b1, 20);
      check_val("rst_mid_ndone", 64'(n_done),         64'(0));
      check_val("rst_mid_nwr",   64'(wq_cyc.size()),  64'(4));
      check_val("rst_mid_nren",  64'(n_ren),          64'(4));

      run_drain(16'h0000, 1'b0, 1'b0, 1'b0, 30);
      check_writes("after_rst", 16'h0000, 0);
      check_val("after_rst_ndone", 64'(n_done), 64'(1));

      run_drain(16'hFFFE, 1'b0, 1'b0, 1'b0, 30);
      check_writes("wrap", 16'hFFFE, 0);
      check_val("wrap_addr2", 64'(wq_addr.size() > 2 ? wq_addr[2] : 16'hDEAD), 64'(16'h0000));
      check_val("wrap_ndone", 64'(n_done), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
